// File: rtl/cla_pkg.sv
// cla_pkg: shared lookahead types, group sizing and the 4-bit propagate/generate helper.
package cla_pkg;
    localparam int CLA_GRP_W = 4;

    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    function automatic int grp_count(input int w);
        return w / CLA_GRP_W;
    endfunction

    // Group P is the AND of the bit propagates, G the lookahead generate across the group.
    function automatic grp_pg_t pg4(input logic [3:0] a, input logic [3:0] b);
        grp_pg_t r;
        logic [3:0] p;
        logic [3:0] g;
        p = a ^ b;
        g = a & b;
        r.p = &p;
        r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction
endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group producing sum, group propagate and generate.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       p,
    output logic       g
);
    logic [3:0] pb;
    logic [3:0] gb;
    logic [3:0] c;

    assign pb   = a ^ b;
    assign gb   = a & b;
    assign c[0] = cin;
    assign c[1] = gb[0] | (pb[0] & cin);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]) | (pb[2] & pb[1] & pb[0] & cin);
    assign sum  = pb ^ c;
    assign p    = &pb;
    assign g    = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1]) | (pb[3] & pb[2] & pb[1] & gb[0]);
endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined carry-lookahead adder with valid/ready handshakes.
// Define CLA_SUB_EN to add the sub port (b inverted, carry-in forced to 1).
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    input  logic                        cin,
`ifdef CLA_SUB_EN
    input  logic                        sub,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            sum,
    output logic                        cout,
    output logic                        ovf,
    output logic [grp_count(WIDTH)-1:0] grp_p,
    output logic [grp_count(WIDTH)-1:0] grp_g
);
    localparam int GROUPS = grp_count(WIDTH);

    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [GROUPS-1:0] p_n;
    logic [GROUPS-1:0] g_n;

    logic              s1_v;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    logic              s1_c0;
    logic [GROUPS-1:0] s1_p;
    logic [GROUPS-1:0] s1_g;

    logic [GROUPS:0]   c;
    logic [WIDTH-1:0]  sum_n;
    logic [GROUPS-1:0] gp_n;
    logic [GROUPS-1:0] gg_n;
    logic              s1_adv;
    logic              s2_adv;

`ifdef CLA_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;
`else
    assign b_eff = b;
    assign c0    = cin;
`endif

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign in_ready = s1_adv;
    assign c[0]     = s1_c0;

    for (genvar k = 0; k < GROUPS; k++) begin : g_grp
        assign {p_n[k], g_n[k]} = pg4(a[CLA_GRP_W*k +: CLA_GRP_W], b_eff[CLA_GRP_W*k +: CLA_GRP_W]);
        assign c[k+1] = s1_g[k] | (s1_p[k] & c[k]);
        cla_group4 u_grp (
            .a   (s1_a[CLA_GRP_W*k +: CLA_GRP_W]),
            .b   (s1_b[CLA_GRP_W*k +: CLA_GRP_W]),
            .cin (c[k]),
            .sum (sum_n[CLA_GRP_W*k +: CLA_GRP_W]),
            .p   (gp_n[k]),
            .g   (gg_n[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_c0     <= 1'b0;
            s1_p      <= '0;
            s1_g      <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            grp_p     <= '0;
            grp_g     <= '0;
        end else begin
            if (s1_adv) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_a  <= a;
                    s1_b  <= b_eff;
                    s1_c0 <= c0;
                    s1_p  <= p_n;
                    s1_g  <= g_n;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    sum   <= sum_n;
                    cout  <= c[GROUPS];
                    // carry into the MSB recovered from the MSB sum bit
                    ovf   <= s1_a[WIDTH-1] ^ s1_b[WIDTH-1] ^ sum_n[WIDTH-1] ^ c[GROUPS];
                    grp_p <= gp_n;
                    grp_g <= gg_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed and exhaustive checks of cla_adder_pipe at WIDTH 16 and 4 against an arithmetic model.
module tb_cla_adder_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid16 = 1'b0, in_ready16, cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        out_valid16, out_ready16 = 1'b1, cout16, ovf16;
    logic [3:0]  grp_p16, grp_g16;

    logic        in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, sub4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0, sum4;
    logic        out_valid4, out_ready4 = 1'b1, cout4, ovf4;
    logic [0:0]  grp_p4, grp_g4;
    logic        rnd4 = 1'b0;

    int vectors = 0;
    int errs    = 0;
    logic [25:0] q16[$];
    logic [25:0] q4[$];

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16),
`ifdef CLA_SUB_EN
        .sub(sub16),
`endif
        .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16),
        .cout(cout16), .ovf(ovf16), .grp_p(grp_p16), .grp_g(grp_g16)
    );

    cla_adder_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
`ifdef CLA_SUB_EN
        .sub(sub4),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4),
        .cout(cout4), .ovf(ovf4), .grp_p(grp_p4), .grp_g(grp_g4)
    );

    task automatic chk(input string n, input logic [25:0] act, input logic [25:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Result packed as {sum[15:0], cout, ovf, grp_p[3:0], grp_g[3:0]} from plain w-bit arithmetic.
    function automatic logic [25:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                          input logic ci, input logic sb);
        logic [16:0] full;
        logic [15:0] mask, be, s;
        logic [3:0]  gp, gg, ak, bk;
        logic        co, ov;
        mask = 16'((17'd1 << w) - 17'd1);
        be   = sb ? (~bv & mask) : (bv & mask);
        full = 17'(av & mask) + 17'(be) + 17'(sb | ci);
        s    = full[15:0] & mask;
        co   = full[w];
        ov   = (av[w-1] == be[w-1]) && (s[w-1] != av[w-1]);
        gp   = '0;
        gg   = '0;
        for (int k = 0; k < w / 4; k++) begin
            ak    = 4'(av >> (4 * k));
            bk    = 4'(be >> (4 * k));
            gp[k] = (ak ^ bk) == 4'hF;
            gg[k] = (5'(ak) + 5'(bk)) > 5'd15;
        end
        return {s, co, ov, gp, gg};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q16.delete();
            q4.delete();
            chk("rst_out16", {out_valid16, sum16, cout16, ovf16, grp_p16, grp_g16}, 0);
            chk("rst_out4", {out_valid4, sum4, cout4, ovf4, grp_p4, grp_g4}, 0);
        end else begin
            if (out_valid16) begin
                if (q16.size() == 0) chk("unexpected16", 26'(out_valid16), 0);
                else begin
                    chk("res16", {sum16, cout16, ovf16, grp_p16, grp_g16}, q16[0]);
                    if (out_ready16) void'(q16.pop_front());
                end
            end
            if (in_valid16 && in_ready16) q16.push_back(model(16, a16, b16, cin16, sub16));
            if (out_valid4) begin
                if (q4.size() == 0) chk("unexpected4", 26'(out_valid4), 0);
                else begin
                    chk("res4", {12'b0, sum4, cout4, ovf4, 3'b0, grp_p4, 3'b0, grp_g4}, q4[0]);
                    if (out_ready4) void'(q4.pop_front());
                end
            end
            if (in_valid4 && in_ready4) q4.push_back(model(4, {12'b0, a4}, {12'b0, b4}, cin4, sub4));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd4) out_ready4 = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive16(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
        a16 = av; b16 = bv; cin16 = ci; sub16 = sb; in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
    endtask

    task automatic one16(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input logic [3:0] ep, input logic [3:0] eg);
        chk("in_ready16", 26'(in_ready16), 1);
        drive16(av, bv, ci, sb);
        chk("lat_s1_valid16", 26'(out_valid16), 0);
        @(posedge clk);
        #1;
        chk("lat_s2_valid16", 26'(out_valid16), 1);
        chk("direct16", {sum16, cout16, ovf16, grp_p16, grp_g16}, {es, ec, eo, ep, eg});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ok;
        int   nsub;
        #2;
        chk("rst_in_ready16", 26'(in_ready16), 1);
        chk("rst_valid_sum16", {out_valid16, sum16}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        one16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110, 4'b0001);
        one16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0110, 4'b0001);
        one16(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 4'b0000, 4'b0000);
        one16(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 4'b1000);
`ifdef CLA_SUB_EN
        one16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b1110, 4'b0000);
        one16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0110, 4'b1000);
`endif

        // backpressure: two beats fill the pipe, the third waits
        out_ready16 = 1'b0;
        a16 = 16'd1; b16 = 16'd1; cin16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_after1", 26'(in_ready16), 1);
        a16 = 16'd2; b16 = 16'd2;
        @(posedge clk);
        #1;
        chk("bp_ready_after2", 26'(in_ready16), 0);
        a16 = 16'd3; b16 = 16'd3;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_hold_ready", 26'(in_ready16), 0);
            chk("bp_hold_out", {out_valid16, sum16}, {1'b1, 16'd2});
        end
        out_ready16 = 1'b1;
        #1;
        chk("bp_release_ready", 26'(in_ready16), 1);
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        chk("bp_drain4", {out_valid16, sum16}, {1'b1, 16'd4});
        @(posedge clk);
        #1;
        chk("bp_drain6", {out_valid16, sum16}, {1'b1, 16'd6});
        @(posedge clk);
        #1;
        chk("bp_empty", 26'(out_valid16), 0);

        // reset with both stages occupied
        drive16(16'd5, 16'd5, 1'b0, 1'b0);
        drive16(16'd6, 16'd6, 1'b0, 1'b0);
        chk("mid_full", {out_valid16, sum16}, {1'b1, 16'd10});
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {out_valid16, sum16, cout16, ovf16}, 0);
        chk("mid_rst_ready", 26'(in_ready16), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_stale16", 26'(out_valid16), 0);
        end
        one16(16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 4'b0100, 4'b0010);

        // WIDTH=4 exhaustive under random backpressure
`ifdef CLA_SUB_EN
        nsub = 2;
`else
        nsub = 1;
`endif
        rnd4 = 1'b1;
        for (int s = 0; s < nsub; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    for (int ci = 0; ci < 2; ci++) begin
                        a4 = 4'(x); b4 = 4'(y); cin4 = 1'(ci); sub4 = 1'(s); in_valid4 = 1'b1;
                        ok = 1'b0;
                        for (int t = 0; t < 50 && !ok; t++) begin
                            @(negedge clk);
                            if (in_ready4) ok = 1'b1;
                            @(posedge clk);
                            #1;
                        end
                        chk("accept4", 26'(ok), 1);
                    end
        in_valid4 = 1'b0;
        for (int t = 0; t < 300 && q4.size() != 0; t++) @(posedge clk);
        rnd4 = 1'b0;
        #2;
        chk("drain4", 26'(q4.size()), 0);
        chk("drain16", 26'(q16.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
